// File: rtl/threshold_sequencer.sv
// Threshold sequencer: counts up to a configurable threshold, repeating for a
// configurable number of match periods per run, then pulses done for one cycle.
// Configuration is accepted only while idle; stop aborts a run without done.
module threshold_sequencer #(
    parameter logic [3:0] DEFAULT_THRESHOLD = 4'b1010,
    parameter logic [3:0] DEFAULT_PERIODS   = 4'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    input  logic [3:0] cfg_threshold,
    input  logic [3:0] cfg_periods,
    output logic       cfg_ready,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] count,
    output logic       match,
    output logic       busy,
    output logic [3:0] periods_left,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A run always has at least one period, so a zero request becomes one.
    function automatic logic [3:0] clamp_periods(input logic [3:0] p);
        if (p == 4'd0) begin
            clamp_periods = 4'd1;
        end else begin
            clamp_periods = p;
        end
    endfunction

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [3:0] periods_left_q, periods_left_d;
    logic [3:0] thr_q, thr_d;
    logic [3:0] per_q, per_d;
    logic       match_s;
    logic       cfg_take_s;

    // Handshake can only complete while idle, since cfg_ready is low elsewhere.
    assign cfg_take_s = cfg_valid && (state_q == ST_IDLE);

    // State register with asynchronous reset to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: counter, remaining periods and active configuration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q        <= 4'd0;
            periods_left_q <= 4'd0;
            thr_q          <= DEFAULT_THRESHOLD;
            per_q          <= clamp_periods(DEFAULT_PERIODS);
        end else begin
            count_q        <= count_d;
            periods_left_q <= periods_left_d;
            thr_q          <= thr_d;
            per_q          <= per_d;
        end
    end

    // Next-state logic; stop takes priority over a match in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (match_s && (periods_left_q == 4'd1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: config latch, period counting and run bookkeeping.
    always_comb begin
        count_d        = count_q;
        periods_left_d = periods_left_q;
        thr_d          = thr_q;
        per_d          = per_q;
        if (cfg_take_s) begin
            thr_d = cfg_threshold;
            per_d = clamp_periods(cfg_periods);
        end else begin
            thr_d = thr_q;
            per_d = per_q;
        end
        case (state_q)
            ST_IDLE: begin
                count_d = 4'd0;
                if (start) begin
                    // Use freshly latched values when config and start coincide.
                    periods_left_d = per_d;
                end else begin
                    periods_left_d = 4'd0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    count_d        = 4'd0;
                    periods_left_d = 4'd0;
                end else if (match_s) begin
                    count_d        = 4'd0;
                    periods_left_d = periods_left_q - 4'd1;
                end else begin
                    count_d        = count_q + 4'd1;
                    periods_left_d = periods_left_q;
                end
            end
            ST_DONE: begin
                count_d        = 4'd0;
                periods_left_d = 4'd0;
            end
            default: begin
                count_d        = 4'd0;
                periods_left_d = 4'd0;
            end
        endcase
    end

    // Output decode from the current state and counter.
    always_comb begin
        cfg_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        match_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
            end
            ST_RUN: begin
                busy    = 1'b1;
                match_s = (count_q == thr_q);
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                cfg_ready = 1'b0;
            end
        endcase
    end

    assign match        = match_s;
    assign count        = count_q;
    assign periods_left = periods_left_q;

endmodule

// File: tb/tb_threshold_sequencer.sv
// Directed, table-driven bench for threshold_sequencer.
module tb_threshold_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic [3:0] cfg_threshold;
    logic [3:0] cfg_periods;
    logic       cfg_ready;
    logic       start;
    logic       stop;
    logic [3:0] count;
    logic       match;
    logic       busy;
    logic [3:0] periods_left;
    logic       done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    threshold_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_threshold(cfg_threshold),
        .cfg_periods  (cfg_periods),
        .cfg_ready    (cfg_ready),
        .start        (start),
        .stop         (stop),
        .count        (count),
        .match        (match),
        .busy         (busy),
        .periods_left (periods_left),
        .done         (done)
    );

    typedef struct {
        logic       cv;
        logic [3:0] thr;
        logic [3:0] per;
        logic       st;
        logic       sp;
        logic [3:0] e_cnt;
        logic       e_match;
        logic       e_busy;
        logic [3:0] e_pl;
        logic       e_done;
        logic       e_rdy;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_cnt, input logic e_match,
                           input logic e_busy, input logic [3:0] e_pl, input logic e_done,
                           input logic e_rdy);
        chk({tag, ".count"}, count, e_cnt);
        chk({tag, ".match"}, {3'd0, match}, {3'd0, e_match});
        chk({tag, ".busy"}, {3'd0, busy}, {3'd0, e_busy});
        chk({tag, ".periods_left"}, periods_left, e_pl);
        chk({tag, ".done"}, {3'd0, done}, {3'd0, e_done});
        chk({tag, ".cfg_ready"}, {3'd0, cfg_ready}, {3'd0, e_rdy});
    endtask

    // All tasks below start and end at a falling edge.
    task automatic do_cfg(input logic [3:0] thr, input logic [3:0] per);
        cfg_valid     = 1'b1;
        cfg_threshold = thr;
        cfg_periods   = per;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Step n RUN cycles against a reference counter model.
    task automatic run_cycles(input string tag, input int thr, input int n,
                              inout int c, inout int pl);
        for (int k = 0; k < n; k++) begin
            chk_all($sformatf("%s.c%0d", tag, k), c[3:0], (c == thr), 1'b1, pl[3:0], 1'b0, 1'b0);
            if (c == thr) begin
                c  = 0;
                pl = pl - 1;
            end else begin
                c = c + 1;
            end
            @(negedge clk);
        end
    endtask

    // Whole run from the first RUN cycle through DONE and back to IDLE.
    task automatic run_check(input string tag, input int thr, input int per);
        int c;
        int pl;
        c  = 0;
        pl = per;
        run_cycles(tag, thr, per * (thr + 1), c, pl);
        chk_all({tag, ".done"}, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk_all({tag, ".idle"}, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    initial begin
        int c;
        int pl;

        // cv thr per st sp | cnt match busy pl done rdy
        vecs[0]  = '{1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 4'd2, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 4'd7, 4'd9, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 4'd7, 4'd9, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};

        reset         = 1'b1;
        cfg_valid     = 1'b0;
        cfg_threshold = 4'd0;
        cfg_periods   = 4'd0;
        start         = 1'b0;
        stop          = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        reset = 1'b0;

        // Defaults: threshold 10, one period.
        do_start();
        run_check("defaults", 10, 1);

        // Table: zero threshold/zero periods, same-edge config+start, ignored inputs.
        for (int i = 0; i < 15; i++) begin
            cfg_valid     = vecs[i].cv;
            cfg_threshold = vecs[i].thr;
            cfg_periods   = vecs[i].per;
            start         = vecs[i].st;
            stop          = vecs[i].sp;
            chk_all($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_match, vecs[i].e_busy,
                    vecs[i].e_pl, vecs[i].e_done, vecs[i].e_rdy);
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;

        // Threshold 3, four periods.
        do_cfg(4'd3, 4'd4);
        do_start();
        run_check("thr3p4", 3, 4);

        // Threshold 15 must reach count 15 without wrapping.
        do_cfg(4'd15, 4'd0);
        do_start();
        run_check("thr15", 15, 1);

        // Stop at count 5 of period 2 while match is high.
        do_cfg(4'd5, 4'd3);
        do_start();
        c  = 0;
        pl = 3;
        run_cycles("stop", 5, 11, c, pl);
        chk_all("stop.at", 4'd5, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk_all("stop.after", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk_all("stop.nodone", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

        // Asynchronous reset mid-run at count 7, then defaults restored.
        do_cfg(4'd12, 4'd2);
        do_start();
        c  = 0;
        pl = 2;
        run_cycles("arst", 12, 7, c, pl);
        chk("arst.pre.count", count, 4'd7);
        #2 reset = 1'b1;
        #1;
        chk_all("arst.async", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        chk_all("arst.held", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        do_start();
        run_check("arst.defaults", 10, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/threshold_sequencer.md
THRESHOLD_SEQUENCER -- requirements
Module: threshold_sequencer

Interface
REQ-001 Parameter DEFAULT_THRESHOLD, default 4'b1010, threshold value loaded at reset.
REQ-002 Parameter DEFAULT_PERIODS, default 4'd1, period count loaded at reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cfg_valid  input  1  configuration offer.
REQ-006 cfg_threshold  input  4  new match threshold.
REQ-007 cfg_periods  input  4  new number of match periods per run.
REQ-008 cfg_ready  output  1  configuration accepted when cfg_valid and cfg_ready are both high at a rising edge.
REQ-009 start  input  1  start a run; sampled only in IDLE.
REQ-010 stop  input  1  abort a run; sampled only in RUN.
REQ-011 count  output  4  running 4-bit count.
REQ-012 match  output  1  combinational; high when in RUN and count == active threshold.
REQ-013 busy  output  1  high in RUN.
REQ-014 periods_left  output  4  matches remaining in the current run.
REQ-015 done  output  1  one-cycle pulse on normal run completion.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-017 IDLE: cfg_ready=1, busy=0, count held at 0, match=0.
REQ-018 Config handshake in IDLE SHALL latch cfg_threshold and cfg_periods into the active registers at that edge.
REQ-019 cfg_periods == 0 SHALL be latched as 1 (zero-period runs are not allowed).
REQ-020 cfg_ready SHALL be 0 in RUN and DONE; cfg_valid there SHALL be ignored and active registers held.
REQ-021 start high in IDLE at edge T SHALL move to RUN with count=0 and periods_left=active periods; if cfg handshake occurs at the same edge, the new values SHALL be used for this run.
REQ-022 RUN: count SHALL increment by 1 each cycle while match=0.
REQ-023 RUN with match=1: at the edge count SHALL return to 0 and periods_left SHALL decrement by 1; period length = threshold+1 cycles.
REQ-024 RUN with match=1 and periods_left==1 SHALL move to DONE with periods_left=0 and count=0.
REQ-025 Threshold 0 SHALL produce match=1 in every RUN cycle (period of 1 cycle).
REQ-026 Threshold 15 SHALL match at count 15; count SHALL never wrap 15->0 other than through a match.
REQ-027 DONE: done=1, busy=0, cfg_ready=0, for exactly one cycle, then unconditionally IDLE.
REQ-028 stop high in RUN SHALL move to IDLE at the next edge, count=0, periods_left=0, no done pulse; stop has priority over a simultaneous match.
REQ-029 start in RUN or DONE and stop in IDLE or DONE SHALL be ignored.
REQ-030 A full run SHALL take periods*(threshold+1) RUN cycles; done SHALL assert the cycle after the final match.

Reset
REQ-031 reset high SHALL immediately (asynchronously) force state IDLE, count=0, periods_left=0, done=0, busy=0, active threshold=DEFAULT_THRESHOLD, active periods=DEFAULT_PERIODS.
REQ-032 reset asserted mid-run SHALL abort without a done pulse; after release the block SHALL be in IDLE with cfg_ready=1.

Verification
REQ-033 Reset, then start with defaults -> RUN cycles 11, match at count=10, done one cycle later, periods_left 1->0.
REQ-034 Config thr=3, periods=4, then start -> match at count 3 four times, 16 RUN cycles, periods_left 4,3,2,1,0, single done pulse.
REQ-035 Config thr=0, periods=0 -> periods latched as 1; start -> one RUN cycle with match=1, then DONE, then IDLE.
REQ-036 Config thr=5, periods=3, start; assert stop at count=5 of period 2 -> IDLE next edge, count=0, periods_left=0, no done.
REQ-037 Same-edge cfg_valid (thr=2, periods=2) and start in IDLE -> run uses thr=2; cfg_valid with thr=7 during RUN ignored; done after 6 RUN cycles.
REQ-038 Assert reset asynchronously mid-run at count=7 -> outputs cleared before next clock edge; threshold restored to 10.
